nios2_mul_pipe: RTL

Parametrised, fully pipelined integer multiply unit for the Nios II custom datapath. Supersedes the fixed 32x32 low-word-only multiplier cell with selectable width, four result modes (low word, and high word with unsigned, signed/unsigned or signed operands), a valid/ready handshake with output back-pressure, a destination tag pass-through and a synchronous flush. Sits between the execute-stage operand mux and the writeback arbiter.

---
 rtl/nios2_mul_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nios2_mul_pipe.sv
// Three-stage pipelined DATA_W x DATA_W multiplier with low/high-word modes,
// valid/ready handshake with output back-pressure, tag pass-through and flush.
module nios2_mul_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned LANE_W = DATA_W / 2;
  localparam int unsigned PROD_W = 2 * DATA_W;

  logic              stall_c;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_a_q, s1_b_q;
  logic [1:0]        s1_mode_q;
  logic [TAG_W-1:0]  s1_tag_q;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_pp_ll_q, s2_pp_lh_q, s2_pp_hl_q, s2_pp_hh_q;
  logic [DATA_W-1:0] s2_pp_ll_d, s2_pp_lh_d, s2_pp_hl_d, s2_pp_hh_d;
  logic [DATA_W-1:0] s2_a_q, s2_b_q;
  logic              s2_a_neg_q, s2_b_neg_q;
  logic              s2_a_neg_d, s2_b_neg_d;
  logic [1:0]        s2_mode_q;
  logic [TAG_W-1:0]  s2_tag_q;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0]  out_tag_q;

  logic [LANE_W-1:0] a_l_c, a_h_c, b_l_c, b_h_c;
  logic [PROD_W-1:0] prod_c;

  // Back-pressure freezes the whole pipe; input is refused while stalled or clearing.
  assign stall_c  = out_valid_q && !out_ready;
  assign in_ready = !stall_c && !reset && !flush;

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  // S1 -> S2: lane partial products and sign-correction flags.
  always_comb begin
    a_l_c      = s1_a_q[LANE_W-1:0];
    a_h_c      = s1_a_q[DATA_W-1:LANE_W];
    b_l_c      = s1_b_q[LANE_W-1:0];
    b_h_c      = s1_b_q[DATA_W-1:LANE_W];
    s2_pp_ll_d = DATA_W'(a_l_c) * DATA_W'(b_l_c);
    s2_pp_lh_d = DATA_W'(a_l_c) * DATA_W'(b_h_c);
    s2_pp_hl_d = DATA_W'(a_h_c) * DATA_W'(b_l_c);
    s2_pp_hh_d = DATA_W'(a_h_c) * DATA_W'(b_h_c);
    s2_a_neg_d = s1_mode_q[1] && s1_a_q[DATA_W-1];
    s2_b_neg_d = (s1_mode_q == 2'b11) && s1_b_q[DATA_W-1];
  end

  // S2 -> S3: unsigned sum, then two's-complement correction of the high word.
  always_comb begin
    prod_c = PROD_W'(s2_pp_ll_q)
           + (PROD_W'(s2_pp_lh_q) << LANE_W)
           + (PROD_W'(s2_pp_hl_q) << LANE_W)
           + (PROD_W'(s2_pp_hh_q) << DATA_W)
           - (s2_a_neg_q ? (PROD_W'(s2_b_q) << DATA_W) : PROD_W'(0))
           - (s2_b_neg_q ? (PROD_W'(s2_a_q) << DATA_W) : PROD_W'(0));
    out_result_d = (s2_mode_q == 2'b00) ? prod_c[DATA_W-1:0] : prod_c[PROD_W-1:DATA_W];
  end

  // Payloads load only behind a valid bit so idle slots leave outputs untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall_c) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (in_valid) begin
        s1_a_q    <= in_a;
        s1_b_q    <= in_b;
        s1_mode_q <= in_mode;
        s1_tag_q  <= in_tag;
      end
      if (s1_valid_q) begin
        s2_pp_ll_q <= s2_pp_ll_d;
        s2_pp_lh_q <= s2_pp_lh_d;
        s2_pp_hl_q <= s2_pp_hl_d;
        s2_pp_hh_q <= s2_pp_hh_d;
        s2_a_q     <= s1_a_q;
        s2_b_q     <= s1_b_q;
        s2_a_neg_q <= s2_a_neg_d;
        s2_b_neg_q <= s2_b_neg_d;
        s2_mode_q  <= s1_mode_q;
        s2_tag_q   <= s1_tag_q;
      end
      if (s2_valid_q) begin
        out_result_q <= out_result_d;
        out_tag_q    <= s2_tag_q;
      end
    end
  end

endmodule
